// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
//
// Eight-way round-robin arbiter with an optional grant hold limit.
//
// A two-state FSM (IDLE / GRANT) picks one requester at a time. The winner
// is the first asserted request found by scanning upward from the slot after
// the previous grantee, wrapping 7 -> 0. A tenure ends when the grantee
// pulses release_pulse, drops its request line, or reaches the hold limit.
// After each tenure the FSM spends at least one cycle in IDLE, so grants are
// never back to back.
//
// The release input is named release_pulse because `release` is a reserved
// word in SystemVerilog.
//
// Parameters
//   MAX_HOLD       maximum cycles a grant may be held; 0 disables the limit
//
// Ports
//   clk            single clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   req[7:0]       level-sensitive request lines, bit i = requester i
//   release_pulse  one-cycle pulse from the grantee ending its tenure
//   gnt_valid      high while a grant is active
//   gnt_idx[2:0]   index of the current or most recent grantee
//   gnt_onehot[7:0] one-hot decode of gnt_idx while gnt_valid, else 0
//   timeout        one-cycle pulse when the hold limit revoked a grant
// -----------------------------------------------------------------------------
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       release_pulse,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] gnt_onehot,
   output logic       timeout
);

   // Counter is wide enough to reach MAX_HOLD-1, never narrower than 1 bit.
   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   // Terminal count. With the limit disabled the counter simply saturates
   // at all-ones and is never used to end a tenure.
   localparam logic [CNT_W-1:0] HOLD_LAST =
      (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

   localparam logic HOLD_EN = (MAX_HOLD > 0);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state;
   logic [2:0]       last_ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic [2:0]       winner;
   logic             owner_done;
   logic             hold_hit;
   logic             tenure_end;

   // Round-robin pick: scan offsets from the highest down to the lowest so
   // the last match written is the closest slot after ptr. The 3-bit sum
   // wraps naturally from 7 to 0. Result is only used when r != 0.
   function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                          input logic [2:0] ptr);
      logic [2:0] pick;
      logic [2:0] idx;
      pick = ptr;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'd1 + 3'(i);
         if (r[idx]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

   always_comb begin
      winner     = rr_pick(req, last_ptr);
      // The grantee ending its own tenure takes precedence over the limit,
      // so a coincident release never produces a timeout pulse.
      owner_done = release_pulse || !req[gnt_idx];
      hold_hit   = HOLD_EN && (hold_cnt == HOLD_LAST);
      tenure_end = owner_done || hold_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_valid  <= 1'b0;
         gnt_idx    <= 3'd0;
         gnt_onehot <= 8'h00;
         timeout    <= 1'b0;
         hold_cnt   <= '0;
         last_ptr   <= 3'd7;   // first arbitration after reset starts at 0
      end else begin
         case (state)
            IDLE: begin
               // Any timeout pulse lasts only for the turnaround cycle.
               timeout <= 1'b0;
               if (req != 8'h00) begin
                  state      <= GRANT;
                  gnt_valid  <= 1'b1;
                  gnt_idx    <= winner;
                  gnt_onehot <= 8'b1 << winner;
                  hold_cnt   <= '0;
               end
            end

            GRANT: begin
               if (tenure_end) begin
                  state      <= IDLE;
                  gnt_valid  <= 1'b0;
                  gnt_onehot <= 8'h00;
                  last_ptr   <= gnt_idx;
                  timeout    <= hold_hit && !owner_done;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
